// File: rtl/vga_overlay_pkg.sv
// rtl/vga_overlay_pkg.sv - shared colours, default geometry and helpers for the status overlay
package vga_overlay_pkg;

  localparam int DEF_X0         = 16;
  localparam int DEF_Y0         = 16;
  localparam int DEF_PITCH_LOG2 = 5;
  localparam int DEF_CELL       = 24;
  localparam int DEF_BITS       = 12;
  localparam int NUM_CELLS      = 8;

  localparam logic [23:0] RGB_ON  = 24'hFF2000;
  localparam logic [23:0] RGB_OFF = 24'h202020;

  // Low bits of dx that give the offset within one square's pitch.
  function automatic int pitch_mask(input int log2);
    return (1 << log2) - 1;
  endfunction

endpackage

// File: rtl/vga_status_overlay_if.sv
// rtl/vga_status_overlay_if.sv - pixel stream in/out of the status overlay stage
interface vga_status_overlay_if;

  logic [7:0] in_red;
  logic [7:0] in_green;
  logic [7:0] in_blue;
  logic       in_hsync;
  logic       in_vsync;
  logic       in_blank;
  logic [7:0] status;
  logic       enable;
  logic [7:0] out_red;
  logic [7:0] out_green;
  logic [7:0] out_blue;
  logic       out_hsync;
  logic       out_vsync;
  logic       out_blank;
  logic       frame_start;

  modport master (
    output in_red, in_green, in_blue, in_hsync, in_vsync, in_blank, status, enable,
    input  out_red, out_green, out_blue, out_hsync, out_vsync, out_blank, frame_start
  );

  modport slave (
    input  in_red, in_green, in_blue, in_hsync, in_vsync, in_blank, status, enable,
    output out_red, out_green, out_blue, out_hsync, out_vsync, out_blank, frame_start
  );

endinterface

// File: rtl/vga_xy_tracker.sv
// rtl/vga_xy_tracker.sv - beam position tracker from blank/vsync for overlay stages
module vga_xy_tracker #(
  parameter int   C_bits      = 12,
  parameter logic C_vsync_pol = 1'b1
) (
  input  logic              clk_pixel,
  input  logic              reset_n,
  input  logic              in_blank,
  input  logic              in_vsync,
  output logic [C_bits-1:0] x,
  output logic [C_bits-1:0] y,
  output logic              line_end,
  output logic              frame_edge
);

  localparam logic [C_bits-1:0] CNT_MAX = '1;

  logic              blank_q;
  logic              vsync_q;
  logic [C_bits-1:0] x_cnt;

  assign line_end   = in_blank & ~blank_q;
  assign frame_edge = (in_vsync == C_vsync_pol) & (vsync_q != C_vsync_pol);
  // x_cnt already holds the position of the current pixel; force 0 on blank cycles.
  assign x          = in_blank ? '0 : x_cnt;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      blank_q <= 1'b1;
      vsync_q <= ~C_vsync_pol;
      x_cnt   <= '0;
      y       <= '0;
    end else begin
      blank_q <= in_blank;
      vsync_q <= in_vsync;
      if (in_blank) begin
        x_cnt <= '0;
      end else if (x_cnt != CNT_MAX) begin
        x_cnt <= x_cnt + 1'b1;
      end
      if (frame_edge) begin
        y <= '0;
      end else if (line_end && (y != CNT_MAX)) begin
        y <= y + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_status_overlay.sv
// rtl/vga_status_overlay.sv - draws 8 status squares over a VGA stream with fixed 2-cycle latency
module vga_status_overlay
  import vga_overlay_pkg::*;
#(
  parameter int          C_x0         = DEF_X0,
  parameter int          C_y0         = DEF_Y0,
  parameter int          C_pitch_log2 = DEF_PITCH_LOG2,
  parameter int          C_cell       = DEF_CELL,
  parameter logic [23:0] C_on_color   = RGB_ON,
  parameter logic [23:0] C_off_color  = RGB_OFF,
  parameter logic        C_vsync_pol  = 1'b1,
  parameter int          C_bits       = DEF_BITS
) (
  input logic                 clk_pixel,
  input logic                 reset_n,
  vga_status_overlay_if.slave vif
);

  // One extra bit so x - C_x0 and the range limits never overflow.
  localparam int           W         = C_bits + 1;
  localparam logic [W-1:0] X_LO      = W'(C_x0);
  localparam logic [W-1:0] X_HI      = W'(C_x0 + NUM_CELLS * (2 ** C_pitch_log2));
  localparam logic [W-1:0] Y_LO      = W'(C_y0);
  localparam logic [W-1:0] Y_HI      = W'(C_y0 + C_cell);
  localparam logic [W-1:0] CELL_MASK = W'(pitch_mask(C_pitch_log2));
  localparam logic [W-1:0] CELL_W    = W'(C_cell);

  logic [C_bits-1:0] x;
  logic [C_bits-1:0] y;
  logic              frame_edge;
  logic [W-1:0]      dx;
  logic              hit;
  logic [2:0]        idx;
  logic [7:0]        shadow;

  logic [23:0]       s1_rgb;
  logic              s1_hsync;
  logic              s1_vsync;
  logic              s1_blank;
  logic              s1_hit;
  logic [2:0]        s1_idx;

  vga_xy_tracker #(
    .C_bits      (C_bits),
    .C_vsync_pol (C_vsync_pol)
  ) u_tracker (
    .clk_pixel  (clk_pixel),
    .reset_n    (reset_n),
    .in_blank   (vif.in_blank),
    .in_vsync   (vif.in_vsync),
    .x          (x),
    .y          (y),
    .line_end   (),
    .frame_edge (frame_edge)
  );

  always_comb begin
    dx  = {1'b0, x} - X_LO;
    idx = dx[C_pitch_log2 +: 3];
    hit = ~vif.in_blank & vif.enable
        & ({1'b0, x} >= X_LO) & ({1'b0, x} < X_HI)
        & ((dx & CELL_MASK) < CELL_W)
        & ({1'b0, y} >= Y_LO) & ({1'b0, y} < Y_HI);
  end

  // Sampled only at frame start so a frame never shows two status values.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
    end else if (frame_edge) begin
      shadow <= vif.status;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      s1_rgb          <= '0;
      s1_hsync        <= ~C_vsync_pol;
      s1_vsync        <= ~C_vsync_pol;
      s1_blank        <= 1'b1;
      s1_hit          <= 1'b0;
      s1_idx          <= '0;
      vif.out_red     <= '0;
      vif.out_green   <= '0;
      vif.out_blue    <= '0;
      vif.out_hsync   <= ~C_vsync_pol;
      vif.out_vsync   <= ~C_vsync_pol;
      vif.out_blank   <= 1'b1;
      vif.frame_start <= 1'b0;
    end else begin
      s1_rgb   <= {vif.in_red, vif.in_green, vif.in_blue};
      s1_hsync <= vif.in_hsync;
      s1_vsync <= vif.in_vsync;
      s1_blank <= vif.in_blank;
      s1_hit   <= hit;
      s1_idx   <= idx;
      if (s1_hit) begin
        {vif.out_red, vif.out_green, vif.out_blue} <= shadow[s1_idx] ? C_on_color : C_off_color;
      end else begin
        {vif.out_red, vif.out_green, vif.out_blue} <= s1_rgb;
      end
      vif.out_hsync   <= s1_hsync;
      vif.out_vsync   <= s1_vsync;
      vif.out_blank   <= s1_blank;
      vif.frame_start <= (s1_vsync == C_vsync_pol) && (vif.out_vsync != C_vsync_pol);
    end
  end

endmodule

// File: tb/tb_vga_status_overlay.sv
// tb/tb_vga_status_overlay.sv - self-checking bench for vga_status_overlay
module tb_vga_status_overlay;

  localparam int H_ACT = 272;
  localparam int H_TOT = 300;
  localparam int V_ACT = 44;
  localparam int V_TOT = 50;
  localparam int N_PROBE = 24;

  logic clk_pixel = 1'b0;
  logic reset_n;

  always #20 clk_pixel = ~clk_pixel;

  vga_status_overlay_if vif ();

  vga_status_overlay dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .vif       (vif)
  );

  typedef struct {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        fs;
    logic        hit;
    logic [2:0]  idx;
    int          px;
    int          py;
  } mrec_t;

  typedef struct {
    int          frame;
    int          px;
    int          py;
    logic [23:0] rgb;
    string       name;
  } probe_t;

  probe_t      probes [N_PROBE];
  mrec_t       m1, mo;
  logic [7:0]  sh_m;
  logic        prev_vs;
  logic        en_v, rn_v;
  logic [7:0]  st_v;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          since_rst = 0;
  int          fs_cnt = 0;
  int          t_hs = 0, t_vs = 0, t_bl = 0;
  logic        in_hs_q = 1'b0, in_vs_q = 1'b0, in_bl_q = 1'b1;
  logic        out_hs_q = 1'b0, out_vs_q = 1'b0, out_bl_q = 1'b1;
  logic [23:0] cap [V_ACT][H_ACT];

  function automatic logic [23:0] ramp(input int px, input int py);
    return {px[7:0], py[7:0], px[7:0] ^ py[7:0]};
  endfunction

  // Default geometry: squares at x 16+32k .. 16+32k+23, y 16..39.
  function automatic logic model_hit(input int px, input int py, input logic bl, input logic en);
    return en && !bl && px >= 16 && px < 16 + 256 && ((px - 16) % 32) < 24 && py >= 16 && py < 40;
  endfunction

  function automatic mrec_t rst_rec();
    mrec_t r;
    r.rgb = '0; r.hs = 1'b0; r.vs = 1'b0; r.bl = 1'b1; r.fs = 1'b0;
    r.hit = 1'b0; r.idx = '0; r.px = -1; r.py = -1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic [23:0] rgb, input logic hs, input logic vs, input logic bl,
                      input int px, input int py);
    mrec_t n1, no;
    @(negedge clk_pixel);
    cyc++;
    check("pix", {vif.out_red, vif.out_green, vif.out_blue, vif.out_hsync, vif.out_vsync,
                  vif.out_blank, vif.frame_start}, {mo.rgb, mo.hs, mo.vs, mo.bl, mo.fs});
    if (since_rst >= 3) begin
      if (vif.out_hsync && !out_hs_q) check("hsync_latency", cyc - t_hs, 2);
      if (vif.out_vsync && !out_vs_q) check("vsync_latency", cyc - t_vs, 2);
      if (vif.out_blank && !out_bl_q) check("blank_latency", cyc - t_bl, 2);
    end
    if (vif.frame_start) fs_cnt++;
    if (!mo.bl && mo.px >= 0 && mo.px < H_ACT && mo.py >= 0 && mo.py < V_ACT)
      cap[mo.py][mo.px] = {vif.out_red, vif.out_green, vif.out_blue};
    out_hs_q = vif.out_hsync;
    out_vs_q = vif.out_vsync;
    out_bl_q = vif.out_blank;

    vif.in_red   = rgb[23:16];
    vif.in_green = rgb[15:8];
    vif.in_blue  = rgb[7:0];
    vif.in_hsync = hs;
    vif.in_vsync = vs;
    vif.in_blank = bl;
    vif.enable   = en_v;
    vif.status   = st_v;
    if (!rn_v && reset_n) begin
      reset_n = 1'b0;
      #1;
      check("async_reset", {vif.out_red, vif.out_green, vif.out_blue, vif.out_hsync, vif.out_vsync,
                            vif.out_blank, vif.frame_start}, {24'h000000, 4'b0010});
    end
    reset_n = rn_v;

    if (!rn_v) begin
      m1 = rst_rec();
      mo = rst_rec();
      sh_m = '0;
      prev_vs = 1'b0;
      since_rst = 0;
    end else begin
      no = rst_rec();
      no.rgb = m1.hit ? (sh_m[m1.idx] ? 24'hFF2000 : 24'h202020) : m1.rgb;
      no.hs = m1.hs; no.vs = m1.vs; no.bl = m1.bl;
      no.fs = m1.vs & ~mo.vs;
      no.px = m1.px; no.py = m1.py;
      n1.rgb = rgb; n1.hs = hs; n1.vs = vs; n1.bl = bl;
      n1.hit = model_hit(px, py, bl, en_v);
      n1.idx = (px >= 16) ? 3'((px - 16) / 32) : 3'd0;
      n1.px = px; n1.py = py;
      if (vs && !prev_vs) sh_m = st_v;
      prev_vs = vs;
      m1 = n1;
      mo = no;
      since_rst++;
    end
    if (hs && !in_hs_q) t_hs = cyc;
    if (vs && !in_vs_q) t_vs = cyc;
    if (bl && !in_bl_q) t_bl = cyc;
    in_hs_q = hs; in_vs_q = vs; in_bl_q = bl;
  endtask

  task automatic gen_line(input int n_act, input int n_blank, input int py, input bit vs_end);
    for (int i = 0; i < n_act; i++) step(ramp(i, py), 1'b0, 1'b0, 1'b0, (i < 4095) ? i : 4095, py);
    for (int j = 0; j < n_blank; j++) step(ramp(0, py), j == 1, vs_end && j < 2, 1'b1, 0, py);
  endtask

  task automatic run_probes(input int frame);
    for (int k = 0; k < N_PROBE; k++) begin
      if (probes[k].frame == frame)
        check(probes[k].name, cap[probes[k].py][probes[k].px], probes[k].rgb);
    end
  endtask

  task automatic clear_cap();
    foreach (cap[i, j]) cap[i][j] = 'x;
  endtask

  initial begin
    probes[0]  = '{0, 16, 16, 24'h202020, "f0_sq0_shadow_zero"};
    probes[1]  = '{0, 240, 16, 24'h202020, "f0_sq7_shadow_zero"};
    probes[2]  = '{0, 40, 16, 24'h281038, "f0_gap_pass"};
    probes[3]  = '{1, 16, 16, 24'hFF2000, "f1_sq0_on"};
    probes[4]  = '{1, 48, 16, 24'h202020, "f1_sq1_off"};
    probes[5]  = '{1, 39, 16, 24'hFF2000, "f1_sq0_right_edge"};
    probes[6]  = '{1, 40, 16, 24'h281038, "f1_sq0_past_edge"};
    probes[7]  = '{1, 16, 40, 24'h102838, "f1_below_squares"};
    probes[8]  = '{1, 80, 16, 24'hFF2000, "f1_sq2_on"};
    probes[9]  = '{1, 112, 20, 24'h202020, "f1_sq3_off"};
    probes[10] = '{1, 240, 16, 24'hFF2000, "f1_sq7_on"};
    probes[11] = '{1, 263, 39, 24'hFF2000, "f1_sq7_corner"};
    probes[12] = '{1, 264, 16, 24'h081018, "f1_past_sq7"};
    probes[13] = '{1, 16, 15, 24'h100F1F, "f1_above_squares"};
    probes[14] = '{1, 48, 35, 24'h202020, "f1_no_tearing"};
    probes[15] = '{2, 48, 16, 24'hFF2000, "f2_sq1_now_on"};
    probes[16] = '{2, 112, 19, 24'hFF2000, "f2_sq3_now_on"};
    probes[17] = '{2, 19, 20, 24'hFF2000, "f2_before_disable"};
    probes[18] = '{2, 20, 20, 24'h141400, "f2_at_disable"};
    probes[19] = '{3, 16, 16, 24'h101000, "f3_disabled_sq0"};
    probes[20] = '{3, 48, 16, 24'h301020, "f3_disabled_sq1"};
    probes[21] = '{4, 16, 15, 24'h100F1F, "clear_wins_line15"};
    probes[22] = '{4, 16, 16, 24'hFF2000, "clear_wins_line16"};
    probes[23] = '{4, 19, 16, 24'hFF2000, "clear_wins_line16_x19"};

    reset_n = 1'b0;
    rn_v = 1'b0;
    en_v = 1'b1;
    st_v = 8'hA5;
    vif.in_red = '0; vif.in_green = '0; vif.in_blue = '0;
    vif.in_hsync = 1'b0; vif.in_vsync = 1'b0; vif.in_blank = 1'b1;
    vif.enable = 1'b1; vif.status = 8'hA5;
    m1 = rst_rec();
    mo = rst_rec();
    sh_m = '0;
    prev_vs = 1'b0;

    repeat (2) step(24'h0, 1'b0, 1'b0, 1'b1, 0, 0);
    rn_v = 1'b1;

    for (int f = 0; f < 4; f++) begin
      fs_cnt = 0;
      clear_cap();
      for (int v = 0; v < V_TOT; v++) begin
        for (int h = 0; h < H_TOT; h++) begin
          if (f == 0 && v == 0) rn_v = !(h >= 100 && h < 103);
          if (f == 1 && v == 30 && h == 0) st_v = 8'hFF;
          if (f == 2 && v == 20) en_v = (h < 20);
          if (f == 2 && v == 21 && h == 0) en_v = 1'b1;
          if (f == 3 && v == 0 && h == 0) en_v = 1'b0;
          step(ramp(h, v), h >= 280 && h < 290, v >= 46 && v < 48, !(h < H_ACT && v < V_ACT), h, v);
        end
      end
      check("frame_start_count", fs_cnt, 1);
      run_probes(f);
    end

    // Blank rise and vsync edge together, then x and y saturation.
    en_v = 1'b1;
    st_v = 8'h01;
    fs_cnt = 0;
    clear_cap();
    for (int l = 0; l < 4; l++) gen_line(20, 4, l, l == 3);
    for (int l = 0; l < 17; l++) gen_line(20, 4, l, 1'b0);
    gen_line(4120, 4, 17, 1'b0);
    for (int k = 0; k < 4100; k++) gen_line(1, 1, (18 + k < 4095) ? 18 + k : 4095, 1'b0);
    gen_line(20, 4, 4095, 1'b0);
    repeat (4) step(24'h0, 1'b0, 1'b0, 1'b1, 0, 0);
    check("frame_start_count_custom", fs_cnt, 1);
    run_probes(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_status_overlay.md
Name: vga_status_overlay

Overview:
- Pixel-domain stage between the `vga` test-picture generator and `vga2dvid`.
- Tracks the beam position from the incoming sync/blank stream and overlays a row of 8 status squares (one per `status` bit) onto the RGB picture.
- Every signal passes through with a fixed latency, so the output stays a legal VGA stream for `vga2dvid`.

Parameters:
- C_x0, 16: left edge of square 0, in active pixels.
- C_y0, 16: top edge of squares, in active lines.
- C_pitch_log2, 5: horizontal pitch between squares = 2**C_pitch_log2 px (32).
- C_cell, 24: square width and height in px; must be ≤ 2**C_pitch_log2.
- C_on_color, 24'hFF2000: RGB888 colour of a square whose bit is 1.
- C_off_color, 24'h202020: RGB888 colour of a square whose bit is 0.
- C_vsync_pol, 1'b1: active level of in_vsync/out_vsync.
- C_bits, 12: width of the x/y counters.

Ports:
- clk_pixel  in  1  pixel clock, 25 MHz for 640x480.
- reset_n  in  1  asynchronous active-low reset.
- in_red  in  8  input red.
- in_green  in  8  input green.
- in_blue  in  8  input blue.
- in_hsync  in  1  input hsync.
- in_vsync  in  1  input vsync.
- in_blank  in  1  input blank (1 = porch/sync).
- status  in  8  indicator bits; may change at any time.
- enable  in  1  1 = overlay drawn, 0 = pure passthrough.
- out_red  out  8  output red.
- out_green  out  8  output green.
- out_blue  out  8  output blue.
- out_hsync  out  1  delayed hsync.
- out_vsync  out  1  delayed vsync.
- out_blank  out  1  delayed blank.
- frame_start  out  1  one-cycle pulse, aligned with the active edge of out_vsync.

Behaviour:
- Reset, asynchronous on reset_n low:
  - out_red/out_green/out_blue = 0, out_blank = 1.
  - out_hsync and out_vsync = ~C_vsync_pol; this polarity applies to both syncs.
  - frame_start = 0.
  - x = 0, y = 0, status shadow = 0, pipeline valid flags cleared.
- Latency: exactly 2 clk_pixel cycles for RGB, hsync, vsync and blank alike, whatever the enable or hit state.
- x counter:
  - x = 0 while in_blank = 1.
  - x increments by 1 on each cycle with in_blank = 0.
  - Saturates at 2**C_bits-1 and never wraps.
- y counter:
  - Increments by 1 on the rising edge of in_blank (end of an active line).
  - Clears to 0 on the active edge of in_vsync.
  - Saturates like x.
  - When a vsync edge and a blank rising edge occur in the same cycle, the clear wins.
- Status shadow: `status` is sampled into the shadow register on the active edge of in_vsync, so there is no mid-frame tearing. Reset mid-frame leaves shadow = 0 until the next vsync edge.
- Stage 1, registered; computes from the current in_* values, x and y:
  - dx = x - C_x0.
  - idx = dx >> C_pitch_log2, 3 bits.
  - hit = ~in_blank & enable & (x ≥ C_x0) & (x < C_x0 + 8·2**C_pitch_log2) & (dx[C_pitch_log2-1:0] < C_cell) & (y ≥ C_y0) & (y < C_y0 + C_cell).
  - The comparison widths are C_bits+1, so there is no overflow.
- Stage 2, registered:
  - RGB = hit ? (shadow[idx] ? C_on_color : C_off_color) : stage-1 RGB.
  - Syncs and blank are copied.
- Blanked pixels are never overwritten; their RGB passes through unchanged.
- frame_start is 1 for exactly the cycle in which out_vsync first shows its active level.
- Square k covers x in [C_x0+32k, C_x0+32k+23] with the defaults. The edge pixels C_x0+32k+23 and C_x0+32k+24 must be tested.
- A mid-frame deassertion of enable takes effect on the very next pixel (no shadowing).

Decomposition:
- Package `vga_overlay_pkg`:
  - The RGB888 colour constants.
  - The default geometry localparams.
  - A helper function for the pitch mask.
- Sub-module `vga_xy_tracker`:
  - Does edge detection on in_blank/in_vsync and runs the x/y counters.
  - Outputs x, y, line_end and frame_edge.
  - Reusable by future overlay/OSD stages.
- The top of this block holds the shadow register and the 2-stage pipeline.

Test Plan:
- Reset mid-line with reset_n low for 3 cycles → outputs are 0, out_blank = 1, syncs inactive; after release, the first frame has shadow = 0 and draws squares in C_off_color.
- Full 640x480 frame from `vga` with status = 8'hA5 and enable = 1 → pixel (16,16) = 24'hFF2000 (bit 0 = 1); (48,16) = 24'h202020 (bit 1 = 0); (39,16) is inside square 0; (40,16) passes through unchanged; (16,40) passes through.
- Latency check → each input edge of hsync, vsync and blank appears on the output exactly 2 cycles later; RGB of a known ramp pixel is delayed by 2.
- status changed from 8'h00 to 8'hFF at line 100 → no change in the current frame; all squares turn on in the next frame; frame_start pulses exactly once per frame, coincident with the out_vsync active edge.
- enable = 0 for a whole frame → output RGB is bit-exact to the input delayed 2 cycles; toggling enable at x = 20 on line 20 affects output from that pixel onward.
- Blank asserted and vsync active edge in the same cycle → y = 0 (clear wins); lines without any active pixels do not advance y past its saturation value.
